// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port backing memory between the fetch and data ports.
// Data wins by default, a starvation limit forces fetch progress, and a hung access times out into a bus error.
module unified_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              state, stateNext;
  logic [STARVE_W-1:0] starveCnt, starveCntNext;
  logic [WAIT_W-1:0]   waitCnt, waitCntNext;
  logic                memReqNext, memWeNext;
  logic [31:0]         memAddrNext, memWdataNext;
  logic [3:0]          memBeNext;
  logic [31:0]         ifRdataNext, dmRdataNext;
  logic                ifDoneNext, dmDoneNext, busErrNext;
  logic                dmReq, starveOk, dataWins, timedOut;

  assign dmReq    = dm_read | dm_write;
  assign starveOk = starveCnt < STARVE_W'(STARVE_LIMIT);
  assign dataWins = dmReq & (~if_req | starveOk);
  assign timedOut = waitCnt == WAIT_W'(TIMEOUT - 1);

  // Stalls release in the same cycle the done pulse is visible.
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = dmReq & ~dm_done;

  // Next-state and next-output logic.
  always_comb begin
    stateNext     = state;
    starveCntNext = starveCnt;
    waitCntNext   = waitCnt;
    memReqNext    = mem_req;
    memWeNext     = mem_we;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    memBeNext     = mem_be;
    ifRdataNext   = if_rdata;
    dmRdataNext   = dm_rdata;
    ifDoneNext    = 1'b0;
    dmDoneNext    = 1'b0;
    busErrNext    = 1'b0;

    case (state)
      IDLE: begin
        if (dataWins) begin
          // Simultaneous read and write is resolved as a write.
          memReqNext   = 1'b1;
          memWeNext    = dm_write;
          memAddrNext  = dm_addr;
          memWdataNext = dm_wdata;
          memBeNext    = dm_write ? dm_be : 4'b1111;
          waitCntNext  = '0;
          stateNext    = BUSY_D;
          if (if_req && starveOk) begin
            starveCntNext = starveCnt + STARVE_W'(1);
          end
        end else if (if_req) begin
          memReqNext    = 1'b1;
          memWeNext     = 1'b0;
          memAddrNext   = if_addr;
          memWdataNext  = '0;
          memBeNext     = 4'b1111;
          waitCntNext   = '0;
          starveCntNext = '0;
          stateNext     = BUSY_I;
        end
      end

      BUSY_I, BUSY_D: begin
        // An ack landing on the timeout cycle still completes normally.
        if (mem_ack || timedOut) begin
          memReqNext = 1'b0;
          busErrNext = ~mem_ack;
          stateNext  = IDLE;
          if (state == BUSY_I) begin
            ifDoneNext  = 1'b1;
            ifRdataNext = mem_ack ? mem_rdata : ERR_DATA;
          end else begin
            dmDoneNext = 1'b1;
            if (!mem_we) begin
              dmRdataNext = mem_ack ? mem_rdata : ERR_DATA;
            end
          end
        end else begin
          waitCntNext = waitCnt + WAIT_W'(1);
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      starveCnt <= '0;
      waitCnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveCntNext;
      waitCnt   <= waitCntNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      mem_be    <= memBeNext;
      if_rdata  <= ifRdataNext;
      dm_rdata  <= dmRdataNext;
      if_done   <= ifDoneNext;
      dm_done   <= dmDoneNext;
      bus_err   <= busErrNext;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed requests, a configurable-latency memory,
// and monitors that pop expected grants/completions as the DUT presents them.
module tb_unified_mem_arbiter;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dcmd_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } grant_t;

  typedef struct {
    logic        isData;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        memAck;
  logic [31:0] mem_rdata;
  logic        respAck;
  logic        lateAck;

  int          checks;
  int          errors;
  int          ackDelay;
  logic        ackEn;
  logic        ifActive;
  logic        dmActive;

  logic [31:0] fetchQ[$];
  dcmd_t       dataQ[$];
  grant_t      grantQ[$];
  done_t       doneQ[$];

  assign memAck = respAck | lateAck;

  unified_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (memAck),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory contents: every word reads as its address xor a fixed pattern.
  function automatic logic [31:0] memModel(input logic [31:0] a);
    return a ^ 32'h2008_0005;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expGrant(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
    grantQ.push_back('{addr: a, we: we, wdata: wd, be: be});
  endtask

  task automatic expDone(input logic isData, input logic [31:0] rd, input logic err);
    doneQ.push_back('{isData: isData, rdata: rd, err: err});
  endtask

  task automatic pushData(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    dataQ.push_back('{write: wr, addr: a, wdata: wd, be: be});
  endtask

  task automatic waitIdle(input string name, input int maxCyc);
    int n = 0;
    while ((doneQ.size() != 0 || grantQ.size() != 0 || fetchQ.size() != 0 ||
            dataQ.size() != 0 || ifActive || dmActive) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= maxCyc) begin
      errors++;
      $display("FAIL %s: not drained after %0d cycles, %0d grants and %0d completions outstanding",
               name, maxCyc, grantQ.size(), doneQ.size());
    end
  endtask

  // Requester ports and memory responder, all driven just after the rising edge.
  initial begin
    logic [31:0] fa;
    dcmd_t       dc;
    int          ackCnt;
    ackCnt    = 0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_read   = 1'b0;
    dm_write  = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    dm_be     = '0;
    respAck   = 1'b0;
    mem_rdata = '0;
    ifActive  = 1'b0;
    dmActive  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      respAck   = 1'b0;
      mem_rdata = $urandom();
      if (rst) begin
        if_req   = 1'b0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        ifActive = 1'b0;
        dmActive = 1'b0;
        ackCnt   = 0;
      end else begin
        if (mem_req && ackEn) begin
          if (ackCnt == ackDelay - 1) begin
            respAck   = 1'b1;
            mem_rdata = memModel(mem_addr);
            ackCnt    = 0;
          end else begin
            ackCnt++;
          end
        end else begin
          ackCnt = 0;
        end
        if (ifActive && if_done) begin
          ifActive = 1'b0;
          if_req   = 1'b0;
        end
        if (!ifActive && fetchQ.size() != 0) begin
          fa       = fetchQ.pop_front();
          if_addr  = fa;
          if_req   = 1'b1;
          ifActive = 1'b1;
        end
        if (dmActive && dm_done) begin
          dmActive = 1'b0;
          dm_read  = 1'b0;
          dm_write = 1'b0;
        end
        if (!dmActive && dataQ.size() != 0) begin
          dc       = dataQ.pop_front();
          dm_addr  = dc.addr;
          dm_wdata = dc.wdata;
          dm_be    = dc.be;
          dm_write = dc.write;
          dm_read  = ~dc.write;
          dmActive = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the grant scoreboard on each new mem_req and the completion scoreboard on each done.
  initial begin
    grant_t g;
    done_t  d;
    logic   prevReq;
    prevReq = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prevReq) begin
        if (grantQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant: unexpected grant addr %h we %b", mem_addr, mem_we);
        end else begin
          g = grantQ.pop_front();
          check("grant_addr", mem_addr, g.addr);
          check("grant_we", 32'(mem_we), 32'(g.we));
          check("grant_be", 32'(mem_be), 32'(g.be));
          if (g.we) check("grant_wdata", mem_wdata, g.wdata);
        end
      end
      prevReq = mem_req;
      if (if_done || dm_done) begin
        if (doneQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done: unexpected completion if_done %b dm_done %b", if_done, dm_done);
        end else begin
          d = doneQ.pop_front();
          check("done_both_ports", 32'(if_done & dm_done), 0);
          check("done_port", 32'(dm_done), 32'(d.isData));
          check("done_rdata", d.isData ? dm_rdata : if_rdata, d.rdata);
          check("done_bus_err", 32'(bus_err), 32'(d.err));
          check("done_mem_req_low", 32'(mem_req), 0);
        end
      end else if (bus_err) begin
        checks++;
        errors++;
        $display("FAIL bus_err: pulse without done, got 1 expected 0");
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int n;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    lateAck  = 1'b0;
    ackEn    = 1'b1;
    ackDelay = 1;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_if_done", 32'(if_done), 0);
    check("rst_dm_done", 32'(dm_done), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_stall_mem", 32'(stall_mem), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, memory acks in the first busy cycle.
    expGrant(32'h0, 1'b0, 32'h0, 4'hF);
    expDone(1'b0, 32'h2008_0005, 1'b0);
    fetchQ.push_back(32'h0);
    n = 0;
    while (!if_req && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("t1_c0_stall_if", 32'(stall_if), 1);
    check("t1_c0_mem_req", 32'(mem_req), 0);
    @(negedge clk);
    check("t1_c1_mem_req", 32'(mem_req), 1);
    check("t1_c1_stall_if", 32'(stall_if), 1);
    @(negedge clk);
    check("t1_c2_if_done", 32'(if_done), 1);
    check("t1_c2_stall_if", 32'(stall_if), 0);
    check("t1_c2_if_rdata", if_rdata, 32'h2008_0005);
    waitIdle("t1_drain", 20);

    // Fetch and load together: data first, fetch right after.
    ackDelay = 2;
    expGrant(32'h10, 1'b0, 32'h0, 4'hF);
    expGrant(32'h4, 1'b0, 32'h0, 4'hF);
    expDone(1'b1, 32'h2008_0015, 1'b0);
    expDone(1'b0, 32'h2008_0001, 1'b0);
    fetchQ.push_back(32'h4);
    pushData(1'b0, 32'h10, 32'h0, 4'h0);
    n = 0;
    while (!if_req && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("t2_stall_mem", 32'(stall_mem), 1);
    n = 0;
    while (!if_done && n < 30) begin
      check("t2_stall_if_held", 32'(stall_if), 1);
      @(negedge clk);
      n++;
    end
    check("t2_if_done_reached", 32'(if_done), 1);
    waitIdle("t2_drain", 20);

    // Fetch held under back-to-back stores: starvation limit forces D,D,D,D,I,D.
    ackDelay = 1;
    for (int i = 0; i < 4; i++) begin
      expGrant(32'h100 + 32'(4 * i), 1'b1, 32'hA000_0000 + 32'(i), 4'b0011);
      expDone(1'b1, 32'h2008_0015, 1'b0);
    end
    expGrant(32'h8, 1'b0, 32'h0, 4'hF);
    expDone(1'b0, 32'h2008_000D, 1'b0);
    expGrant(32'h110, 1'b1, 32'hA000_0004, 4'b0011);
    expDone(1'b1, 32'h2008_0015, 1'b0);
    fetchQ.push_back(32'h8);
    for (int i = 0; i < 5; i++) begin
      pushData(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b0011);
    end
    waitIdle("t3_drain", 60);

    // Load that is never acknowledged times out into a bus error.
    ackEn = 1'b0;
    expGrant(32'h20, 1'b0, 32'h0, 4'hF);
    expDone(1'b1, 32'hDEAD_BEEF, 1'b1);
    pushData(1'b0, 32'h20, 32'h0, 4'h0);
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t4_granted", 32'(mem_req), 1);
    n = 0;
    while (mem_req && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t4_busy_cycles", 32'(n), 64);
    check("t4_dm_done", 32'(dm_done), 1);
    check("t4_bus_err", 32'(bus_err), 1);
    check("t4_err_data", dm_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t4_bus_err_pulse", 32'(bus_err), 0);
    check("t4_dm_done_pulse", 32'(dm_done), 0);
    ackEn = 1'b1;
    expGrant(32'h24, 1'b0, 32'h0, 4'hF);
    expDone(1'b1, 32'h2008_0021, 1'b0);
    pushData(1'b0, 32'h24, 32'h0, 4'h0);
    waitIdle("t4_drain", 20);

    // Reset in the middle of a data access, then a stray ack.
    ackEn = 1'b0;
    expGrant(32'h30, 1'b0, 32'h0, 4'hF);
    pushData(1'b0, 32'h30, 32'h0, 4'h0);
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_granted", 32'(mem_req), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_mem_req_dropped", 32'(mem_req), 0);
    check("t5_no_dm_done", 32'(dm_done), 0);
    check("t5_no_bus_err", 32'(bus_err), 0);
    check("t5_dm_rdata_cleared", dm_rdata, 0);
    check("t5_mem_be_cleared", 32'(mem_be), 0);
    rst = 1'b0;
    lateAck = 1'b1;
    @(negedge clk);
    lateAck = 1'b0;
    check("t5_late_ack_no_done", 32'(dm_done), 0);
    check("t5_late_ack_no_req", 32'(mem_req), 0);
    @(negedge clk);
    check("t5_still_idle", 32'(mem_req | dm_done | if_done), 0);
    ackEn    = 1'b1;
    ackDelay = 1;
    expGrant(32'h34, 1'b0, 32'h0, 4'hF);
    expDone(1'b1, 32'h2008_0031, 1'b0);
    pushData(1'b0, 32'h34, 32'h0, 4'h0);
    waitIdle("t5_drain", 20);

    // Ack lands exactly on the timeout cycle: normal completion.
    ackDelay = 64;
    expGrant(32'h40, 1'b0, 32'h0, 4'hF);
    expDone(1'b1, 32'h2008_0045, 1'b0);
    pushData(1'b0, 32'h40, 32'h0, 4'h0);
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (mem_req && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t6_busy_cycles", 32'(n), 64);
    check("t6_dm_done", 32'(dm_done), 1);
    check("t6_no_bus_err", 32'(bus_err), 0);
    check("t6_dm_rdata", dm_rdata, 32'h2008_0045);
    waitIdle("t6_drain", 20);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
